// File: rtl/shifter_pkg.sv
// Shared op codes and level-grouping helper for the pipelined shifter.
// A group's level range is ceil-divided so early groups never get fewer levels.
package shifter_pkg;

   localparam logic [2:0] OP_SRL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_ROR = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;
   localparam logic [2:0] OP_NOP = 3'b101;

   typedef struct packed {
      logic [7:0] first;
      logic [7:0] last;
   } lvl_range_t;

   function automatic lvl_range_t grp_range(input int g, input int l, input int s);
      lvl_range_t r;
      r.first = 8'((g * l + s - 1) / s);
      r.last  = 8'(((g + 1) * l + s - 1) / s - 1);
      return r;
   endfunction

endpackage

// File: rtl/shift_level.sv
// One mux level: conditionally shifts or rotates by a fixed distance DIST.
module shift_level
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [2:0]       op_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      if (en_i) begin
         case (op_i)
            OP_SRL:  data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
            OP_SLL:  data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
            OP_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
            OP_ROL:  data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
            OP_SRA:  data_o = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
            default: data_o = data_i;
         endcase
      end
   end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) levels split over STAGES register
// stages with a collapsing valid/ready pipeline and a tag carried per op.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_zero
);

   localparam int L = $clog2(WIDTH);

   logic [STAGES-1:0]             v_q, v_d, ld, st_vin;
   logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d, st_din, st_dout;
   logic [STAGES-1:0][2:0]        op_q, op_d, st_op;
   logic [STAGES-1:0][L-1:0]      shamt_q, shamt_d, st_shamt;
   logic [STAGES-1:0][TAG_W-1:0]  tag_q, tag_d, st_tag;

   // A stage can load unless it and every stage downstream of it are full and the sink stalls.
   for (genvar k = 0; k < STAGES; k++) begin : g_ld
      assign ld[k] = out_ready | ~(&v_q[STAGES-1:k]);
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      localparam lvl_range_t R = grp_range(g, L, STAGES);
      localparam int FIRST = int'(R.first);
      localparam int N     = int'(R.last) - FIRST + 1;

      if (g == 0) begin : g_src_in
         assign st_vin[g]   = in_valid;
         assign st_din[g]   = in_data;
         assign st_op[g]    = in_op;
         assign st_shamt[g] = in_shamt;
         assign st_tag[g]   = in_tag;
      end else begin : g_src_reg
         assign st_vin[g]   = v_q[g-1];
         assign st_din[g]   = data_q[g-1];
         assign st_op[g]    = op_q[g-1];
         assign st_shamt[g] = shamt_q[g-1];
         assign st_tag[g]   = tag_q[g-1];
      end

      for (genvar j = 0; j < N; j++) begin : g_lvl
         logic [WIDTH-1:0] lin, lout;
         if (j == 0) begin : g_head
            assign lin = st_din[g];
         end else begin : g_link
            assign lin = g_lvl[j-1].lout;
         end
         shift_level #(.WIDTH(WIDTH), .DIST(1 << (FIRST + j))) u_lvl (
            .op_i   (st_op[g]),
            .en_i   (st_shamt[g][FIRST+j]),
            .data_i (lin),
            .data_o (lout)
         );
      end

      assign st_dout[g] = g_lvl[N-1].lout;
   end

   always_comb begin
      v_d     = v_q;
      data_d  = data_q;
      op_d    = op_q;
      shamt_d = shamt_q;
      tag_d   = tag_q;
      for (int k = 0; k < STAGES; k++) begin
         if (ld[k]) begin
            v_d[k]     = st_vin[k];
            data_d[k]  = st_dout[k];
            op_d[k]    = st_op[k];
            shamt_d[k] = st_shamt[k];
            tag_d[k]   = st_tag[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= '0;
         data_q  <= '0;
         op_q    <= '0;
         shamt_q <= '0;
         tag_q   <= '0;
      end else begin
         v_q     <= v_d;
         data_q  <= data_d;
         op_q    <= op_d;
         shamt_q <= shamt_d;
         tag_q   <= tag_d;
      end
   end

   // Last-stage op and consumed shamt bits have no reader; keep them out of lint noise.
   logic unused_route;
   assign unused_route = ^{op_q, shamt_q};

   assign in_ready  = ld[0];
   assign out_valid = v_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign out_zero  = ~|data_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter across four width/stage configurations.
module tb_pipelined_shifter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int          sel;
   logic        in_valid, out_ready;
   logic [2:0]  in_op;
   logic [4:0]  in_shamt;
   logic [31:0] in_data;
   logic [3:0]  in_tag;

   logic [3:0]        iv, ordy, ir, ov, oz;
   logic [3:0][31:0]  od;
   logic [3:0][3:0]   ot;
   logic [7:0]        od8;

   for (genvar i = 0; i < 4; i++) begin : g_sel
      assign iv[i]   = in_valid && (sel == i);
      assign ordy[i] = out_ready && (sel == i);
   end
   assign od[3] = {24'd0, od8};

   pipelined_shifter #(.WIDTH(32), .STAGES(1), .TAG_W(4)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(in_op),
      .in_shamt(in_shamt), .in_data(in_data), .in_tag(in_tag), .out_valid(ov[0]),
      .out_ready(ordy[0]), .out_data(od[0]), .out_tag(ot[0]), .out_zero(oz[0]));
   pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_s2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(in_op),
      .in_shamt(in_shamt), .in_data(in_data), .in_tag(in_tag), .out_valid(ov[1]),
      .out_ready(ordy[1]), .out_data(od[1]), .out_tag(ot[1]), .out_zero(oz[1]));
   pipelined_shifter #(.WIDTH(32), .STAGES(5), .TAG_W(4)) u_s5 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_op(in_op),
      .in_shamt(in_shamt), .in_data(in_data), .in_tag(in_tag), .out_valid(ov[2]),
      .out_ready(ordy[2]), .out_data(od[2]), .out_tag(ot[2]), .out_zero(oz[2]));
   pipelined_shifter #(.WIDTH(8), .STAGES(2), .TAG_W(4)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_op(in_op),
      .in_shamt(in_shamt[2:0]), .in_data(in_data[7:0]), .in_tag(in_tag), .out_valid(ov[3]),
      .out_ready(ordy[3]), .out_data(od8), .out_tag(ot[3]), .out_zero(oz[3]));

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          n_push = 0;
   bit          lat_chk = 0;
   bit          use_dir = 0;
   logic [31:0] dir_exp;

   function automatic int cfg_w(input int i);
      return (i == 3) ? 8 : 32;
   endfunction

   function automatic int cfg_s(input int i);
      case (i)
         0:       return 1;
         2:       return 5;
         default: return 2;
      endcase
   endfunction

   function automatic logic [31:0] model(input logic [2:0] op, input int sh_in,
                                         input logic [31:0] d, input int w);
      logic [63:0] m, x, r;
      int sh;
      m  = (64'd1 << w) - 64'd1;
      x  = {32'd0, d} & m;
      sh = sh_in % w;
      r  = x;
      case (op)
         3'd0: r = x >> sh;
         3'd1: r = x << sh;
         3'd2: r = (x >> sh) | (x << (w - sh));
         3'd3: r = (x << sh) | (x >> (w - sh));
         3'd4: begin
            r = x >> sh;
            if (x[w-1]) r = r | (m & ~(m >> sh));
         end
         default: r = x;
      endcase
      r = r & m;
      return r[31:0];
   endfunction

   // Called at a negedge with inputs set: records transfers of the coming posedge, then advances.
   task automatic step();
      exp_t e;
      #1;
      if (iv[sel] && ir[sel]) begin
         e.data = use_dir ? dir_exp : model(in_op, int'(in_shamt), in_data, cfg_w(sel));
         e.tag  = in_tag;
         e.cyc  = cyc;
         sb.push_back(e);
         n_push++;
      end
      if (ov[sel] && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL spurious_out dut=%0d got tag=%0h data=%h expected none", sel, ot[sel], od[sel]);
         end else begin
            e = sb.pop_front();
            total++;
            if (od[sel] !== e.data) begin
               bad++;
               $display("FAIL out_data dut=%0d tag=%0h got=%h exp=%h", sel, e.tag, od[sel], e.data);
            end
            total++;
            if (ot[sel] !== e.tag) begin
               bad++;
               $display("FAIL out_tag dut=%0d got=%0h exp=%0h", sel, ot[sel], e.tag);
            end
            total++;
            if (oz[sel] !== (e.data == 32'd0)) begin
               bad++;
               $display("FAIL out_zero dut=%0d got=%b exp=%b", sel, oz[sel], e.data == 32'd0);
            end
            if (lat_chk) begin
               total++;
               if (cyc - e.cyc != cfg_s(sel)) begin
                  bad++;
                  $display("FAIL latency dut=%0d got=%0d exp=%0d", sel, cyc - e.cyc, cfg_s(sel));
               end
            end
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && sb.size() > 0; n++) step();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout dut=%0d got %0d pending exp 0", sel, sb.size());
      end
   endtask

   task automatic test_reset();
      sel = 1; in_valid = 0; out_ready = 0;
      in_op = 0; in_shamt = 0; in_data = 0; in_tag = 0;
      #2;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (ov[i] !== 1'b0 || oz[i] !== 1'b1 || od[i] !== 32'd0 || ot[i] !== 4'd0) begin
            bad++;
            $display("FAIL reset_state dut=%0d got v=%b z=%b d=%h t=%h exp v=0 z=1 d=0 t=0",
                     i, ov[i], oz[i], od[i], ot[i]);
         end
      end
      @(negedge clk);
      rst_n = 1;
      #1;
      total++;
      if (ir !== 4'hF) begin
         bad++;
         $display("FAIL reset_in_ready got=%b exp=1111", ir);
      end
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [2:0]  t_op[10]  = '{3'd1, 3'd4, 3'd0, 3'd4, 3'd2, 3'd3, 3'd6, 3'd0, 3'd2, 3'd4};
      logic [4:0]  t_sh[10]  = '{5'd31, 5'd4, 5'd4, 5'd4, 5'd31, 5'd1, 5'd7, 5'd1, 5'd0, 5'd0};
      logic [31:0] t_in[10]  = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h7FFFFFF0,
                                 32'h00000001, 32'h80000001, 32'hDEADBEEF, 32'h00000001,
                                 32'h12345678, 32'h80000000};
      logic [31:0] t_exp[10] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'h07FFFFFF,
                                 32'h00000002, 32'h00000003, 32'hDEADBEEF, 32'h00000000,
                                 32'h12345678, 32'h80000000};
      sel = 1; out_ready = 1; lat_chk = 1; use_dir = 1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; in_op = t_op[i]; in_shamt = t_sh[i]; in_data = t_in[i];
         in_tag = 4'(i); dir_exp = t_exp[i];
         step();
      end
      in_valid = 0;
      drain();
      lat_chk = 0; use_dir = 0;
   endtask

   task automatic test_backpressure();
      sel = 1; out_ready = 0; in_op = 3'b101; in_shamt = 0;
      for (int t = 1; t <= 2; t++) begin
         in_valid = 1; in_data = 32'(t); in_tag = 4'(t);
         step();
      end
      in_data = 32'd3; in_tag = 4'd3;
      #1;
      total++;
      if (ir[1] !== 1'b0) begin
         bad++;
         $display("FAIL bp_in_ready_full got=%b exp=0", ir[1]);
      end
      step();
      for (int k = 0; k < 2; k++) begin
         #1;
         total++;
         if (sb.size() < 1 || ov[1] !== 1'b1 || od[1] !== sb[0].data || ot[1] !== sb[0].tag) begin
            bad++;
            $display("FAIL bp_stall_stable got v=%b d=%h t=%h exp v=1 d=1 t=1", ov[1], od[1], ot[1]);
         end
         step();
      end
      out_ready = 1;
      #1;
      total++;
      if (ir[1] !== 1'b1 || ov[1] !== 1'b1 || ot[1] !== 4'd1) begin
         bad++;
         $display("FAIL bp_accept_on_retire got rdy=%b v=%b t=%h exp rdy=1 v=1 t=1", ir[1], ov[1], ot[1]);
      end
      step();
      in_valid = 0;
      for (int k = 0; k < 2; k++) begin
         #1;
         total++;
         if (ov[1] !== 1'b1) begin
            bad++;
            $display("FAIL bp_consecutive got v=%b exp 1", ov[1]);
         end
         step();
      end
      total++;
      if (sb.size() != 0 || n_push < 3) begin
         bad++;
         $display("FAIL bp_empty got pending=%0d exp 0", sb.size());
      end
   endtask

   task automatic test_stream(input int idx);
      int start;
      sel = idx; start = n_push;
      for (int c = 0; c < 2000 && (n_push - start) < 100; c++) begin
         in_valid  = ($urandom_range(0, 9) < 8);
         in_op     = 3'($urandom_range(0, 7));
         in_shamt  = 5'($urandom_range(0, cfg_w(idx) - 1));
         in_data   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         in_tag    = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      in_valid = 0; out_ready = 1;
      drain();
      total++;
      if (n_push - start < 100) begin
         bad++;
         $display("FAIL stream_accepts dut=%0d got=%0d exp=100", idx, n_push - start);
      end
   endtask

   task automatic test_reset_midflight();
      sel = 1; out_ready = 0; in_op = 3'd1; in_shamt = 5'd3;
      for (int t = 0; t < 2; t++) begin
         in_valid = 1; in_data = 32'h11 + 32'(t); in_tag = 4'(8 + t);
         step();
      end
      in_valid = 0;
      @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      total++;
      if (ov[1] !== 1'b0 || oz[1] !== 1'b1 || od[1] !== 32'd0) begin
         bad++;
         $display("FAIL rst_mid_async got v=%b z=%b d=%h exp v=0 z=1 d=0", ov[1], oz[1], od[1]);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1; out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if (ir[1] !== 1'b1 || ov[1] !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_after got rdy=%b v=%b exp rdy=1 v=0", ir[1], ov[1]);
         end
         step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      for (int i = 0; i < 4; i++) test_stream(i);
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
